// File: rtl/comet2_ram_pkg.sv
// comet2_ram_pkg: shared state encoding, word width and address range helper
// for the COMET II wait-state RAM.
`default_nettype none

package comet2_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } ram_state_t;

  localparam int COMET2_WORD_W = 16;

  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/comet2_ram_array.sv
// ============================================================================
// Module      : comet2_ram_array
// Description : DEPTH x DW single-port storage with synchronous write and
//               read-enabled synchronous read.
// Revision    : 1.1
// ============================================================================
`default_nettype none

module comet2_ram_array #(
    parameter int    DW        = 16,
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = "",
    localparam int   c_IW      = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic            i_re,
    input  logic [c_IW-1:0] i_addr,
    input  logic [DW-1:0]   i_wdata,
    output logic [DW-1:0]   o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/comet2_wait_ram.sv
// comet2_wait_ram: req/ack word RAM with WAIT_CYC wait states and range error.
// Define COMET2_RAM_WPROT_EN to reject writes below PROT_LIMIT.
`default_nettype none

module comet2_wait_ram
  import comet2_ram_pkg::*;
#(
  parameter int            AW         = 16,
  parameter int            DW         = COMET2_WORD_W,
  parameter int            DEPTH      = 256,
  parameter int            WAIT_CYC   = 0,
  parameter string         INIT_FILE  = "",
  parameter logic [AW-1:0] PROT_LIMIT = 16'h0050
) (
  input  logic          mclk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          err
);

  localparam int         IW          = $clog2(DEPTH);
  localparam logic [3:0] c_WAIT_LAST = 4'(WAIT_CYC - 1);
`ifdef COMET2_RAM_WPROT_EN
  localparam bit         c_WPROT     = 1'b1;
`else
  localparam bit         c_WPROT     = 1'b0;
`endif

  ram_state_t    r_state, w_next;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic          r_ack, r_err, r_rd_zero;
  logic          w_in_range, w_err, w_commit;
  logic [DW-1:0] w_q;

  // Protection only ever applies to writes; reads fail on range alone.
  assign w_in_range = in_range(32'(r_addr), DEPTH);
  assign w_err      = !w_in_range || (c_WPROT && r_we && (r_addr < PROT_LIMIT));
  assign w_commit   = (r_state == ST_ACK) && !rst;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req) w_next = (WAIT_CYC > 0) ? ST_WAIT : ST_ACK;
      ST_WAIT: if (r_cnt == c_WAIT_LAST) w_next = ST_ACK;
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge mclk) begin
    if (r_state == ST_IDLE && req) begin
      r_addr  <= addr;
      r_we    <= we;
      r_wdata <= wdata;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rd_zero <= 1'b1;
    end else begin
      r_cnt <= (r_state == ST_WAIT) ? r_cnt + 4'd1 : 4'd0;
      r_ack <= (r_state == ST_ACK);
      r_err <= (r_state == ST_ACK) && w_err;
      if (r_state == ST_ACK && !r_we) r_rd_zero <= w_err;
    end
  end

  comet2_ram_array #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (mclk),
    .i_we    (w_commit && r_we && !w_err),
    .i_re    (w_commit && !r_we && !w_err),
    .i_addr  (r_addr[IW-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_q)
  );

  // The array output register is left alone on rejected reads; mask it instead.
  assign rdata = r_rd_zero ? '0 : w_q;
  assign ack   = r_ack;
  assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_comet2_wait_ram.sv
// tb_comet2_wait_ram: scoreboard bench over three RAM instances (WAIT_CYC 0, 3, 2).
`default_nettype none

module tb_comet2_wait_ram;

  localparam int NI = 3;
`ifdef COMET2_RAM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic [NI-1:0]       rst, req, we, ack, err;
  logic [NI-1:0][15:0] addr, wdata, rdata;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] rd;
    logic        e;
    int          lat;
    bit          chk_rd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    comet2_wait_ram #(
      .AW(16), .DW(16), .DEPTH(256),
      .WAIT_CYC((g == 1) ? 3 : (g == 2) ? 2 : 0),
      .INIT_FILE(""), .PROT_LIMIT(16'h0050)
    ) u_dut (
      .mclk(clk), .rst(rst[g]), .req(req[g]), .we(we[g]), .addr(addr[g]),
      .wdata(wdata[g]), .ack(ack[g]), .rdata(rdata[g]), .err(err[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 1) ? 3 : (k == 2) ? 2 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one access and waits for ack; lat = edges after the sampling edge, -1 on timeout.
  task automatic do_access(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output logic e, output int lat, output logic stray);
    int n = 0;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    stray = 1'b0;
    do begin
      tick();
      n++;
      if (!ack[k] && err[k]) stray = 1'b1;
    end while (!ack[k] && n < 40);
    rd  = rdata[k];
    e   = err[k];
    lat = ack[k] ? n - 1 : -1;
    req[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = '1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) tick();
    for (int k = 0; k < NI; k++) begin
      checks++; if (ack[k] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b want 0", k, ack[k]); end
      checks++; if (err[k] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b want 0", k, err[k]); end
      checks++; if (rdata[k] !== 16'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0000", k, rdata[k]); end
    end
    rst = '0;
    tick();
  endtask

  task automatic test_basic();
    logic        sw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] sa [4] = '{16'h00C0, 16'h00C0, 16'h0003, 16'h0003};
    logic [15:0] sd [4] = '{16'h5a5a, 16'h0000, 16'h1357, 16'h0000};
    logic [15:0] rd; logic e, stray; int lat; exp_t x;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{rd: (i == 1) ? 16'h5a5a : 16'h1357, e: 1'b0, lat: 1, chk_rd: !sw[i]});
      do_access(0, sw[i], sa[i], sd[i], rd, e, lat, stray);
      x = sb.pop_front();
      checks++; if (lat !== x.lat) begin errors++; $display("FAIL basic_lat[%0d]: got %0d want %0d", i, lat, x.lat); end
      checks++; if (e !== x.e) begin errors++; $display("FAIL basic_err[%0d]: got %b want %b", i, e, x.e); end
      checks++; if (stray) begin errors++; $display("FAIL basic_err_without_ack[%0d]: got 1 want 0", i); end
      if (x.chk_rd) begin
        checks++; if (rd !== x.rd) begin errors++; $display("FAIL basic_rdata[%0d]: got %h want %h", i, rd, x.rd); end
      end
    end
  endtask

  task automatic test_wait();
    logic [15:0] rd; logic e, stray; int lat; exp_t x;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{rd: 16'h0050, e: 1'b0, lat: 1 + wc(1), chk_rd: (i == 1)});
      do_access(1, (i == 0), 16'h0001, 16'h0050, rd, e, lat, stray);
      x = sb.pop_front();
      checks++; if (lat !== x.lat) begin errors++; $display("FAIL wait_lat[%0d]: got %0d want %0d", i, lat, x.lat); end
      checks++; if (e !== x.e) begin errors++; $display("FAIL wait_err[%0d]: got %b want %b", i, e, x.e); end
      if (x.chk_rd) begin
        checks++; if (rd !== x.rd) begin errors++; $display("FAIL wait_rdata: got %h want %h", rd, x.rd); end
      end
    end
    repeat (3) tick();
    checks++; if (rdata[1] !== 16'h0050) begin errors++; $display("FAIL wait_rdata_hold: got %h want 0050", rdata[1]); end
    checks++; if (ack[1] !== 1'b0) begin errors++; $display("FAIL wait_ack_single: got %b want 0", ack[1]); end
  endtask

  task automatic test_range();
    logic        sw [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] sa [6] = '{16'h0000, 16'h00FF, 16'h0100, 16'h0000, 16'h00FF, 16'h0100};
    logic [15:0] sd [6] = '{16'hbeef, 16'h0f0f, 16'hffff, 16'h0, 16'h0, 16'h0};
    logic [15:0] er [6] = '{16'h0, 16'h0, 16'h0, 16'hbeef, 16'h0f0f, 16'h0000};
    logic        ee [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] rd; logic e, stray; int lat; exp_t x;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{rd: er[i], e: ee[i], lat: 1, chk_rd: !sw[i]});
      do_access(0, sw[i], sa[i], sd[i], rd, e, lat, stray);
      x = sb.pop_front();
      checks++; if (lat !== x.lat) begin errors++; $display("FAIL range_lat[%0d]: got %0d want %0d", i, lat, x.lat); end
      checks++; if (e !== x.e) begin errors++; $display("FAIL range_err[%0d]: got %b want %b", i, e, x.e); end
      checks++; if (stray) begin errors++; $display("FAIL range_err_without_ack[%0d]: got 1 want 0", i); end
      if (x.chk_rd) begin
        checks++; if (rd !== x.rd) begin errors++; $display("FAIL range_rdata[%0d]: got %h want %h", i, rd, x.rd); end
      end
    end
  endtask

  task automatic test_wprot();
    logic        sw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] sa [4] = '{16'h004F, 16'h004F, 16'h0050, 16'h0050};
    logic [15:0] rd; logic e, stray; int lat; exp_t x;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{rd: 16'h1234, e: (i == 0) && WPROT, lat: 1, chk_rd: (i == 3) || (i == 1 && !WPROT)});
      do_access(0, sw[i], sa[i], 16'h1234, rd, e, lat, stray);
      x = sb.pop_front();
      checks++; if (lat !== x.lat) begin errors++; $display("FAIL wprot_lat[%0d]: got %0d want %0d", i, lat, x.lat); end
      checks++; if (e !== x.e) begin errors++; $display("FAIL wprot_err[%0d]: got %b want %b", i, e, x.e); end
      if (x.chk_rd) begin
        checks++; if (rd !== x.rd) begin errors++; $display("FAIL wprot_rdata[%0d]: got %h want %h", i, rd, x.rd); end
      end
    end
  endtask

  task automatic test_rst_abort();
    logic [15:0] rd; logic e, stray, saw; int lat; exp_t x;
    do_access(2, 1'b1, 16'h00FF, 16'h1111, rd, e, lat, stray);
    checks++; if (lat !== 1 + wc(2)) begin errors++; $display("FAIL abort_setup_lat: got %0d want %0d", lat, 1 + wc(2)); end
    // Abort once while waiting, once in the cycle before the commit edge.
    for (int p = 0; p < 2; p++) begin
      do_access(2, 1'b0, 16'h00FF, 16'h0, rd, e, lat, stray);
      req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h00FF; wdata[2] = 16'ha5a5;
      tick();
      req[2] = 1'b0;
      repeat (1 + p) tick();
      rst[2] = 1'b1;
      tick();
      saw = ack[2];
      rst[2] = 1'b0;
      repeat (5) begin tick(); saw |= ack[2]; end
      checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_no_ack[%0d]: got %b want 0", p, saw); end
      checks++; if (rdata[2] !== 16'h0) begin errors++; $display("FAIL abort_rdata_cleared[%0d]: got %h want 0000", p, rdata[2]); end
      sb.push_back('{rd: 16'h1111, e: 1'b0, lat: 1 + wc(2), chk_rd: 1'b1});
      do_access(2, 1'b0, 16'h00FF, 16'h0, rd, e, lat, stray);
      x = sb.pop_front();
      checks++; if (lat !== x.lat) begin errors++; $display("FAIL abort_read_lat[%0d]: got %0d want %0d", p, lat, x.lat); end
      checks++; if (rd !== x.rd) begin errors++; $display("FAIL abort_unchanged[%0d]: got %h want %h", p, rd, x.rd); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic e, stray; int lat; exp_t x;
    int cyc = 0, last = 0, n = 0;
    for (int i = 0; i < 3; i++) do_access(0, 1'b1, 16'h0010 + 16'(i), 16'h0111 * 16'(i + 1), rd, e, lat, stray);
    for (int i = 0; i < 3; i++) sb.push_back('{rd: 16'h0111 * 16'(i + 1), e: 1'b0, lat: 2, chk_rd: 1'b1});
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
    while (n < 3 && cyc < 30) begin
      tick();
      cyc++;
      if (ack[0]) begin
        x = sb.pop_front();
        checks++; if (rdata[0] !== x.rd) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", n, rdata[0], x.rd); end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d]: got %b want 0", n, err[0]); end
        checks++; if (cyc - last !== x.lat) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", n, cyc - last, x.lat); end
        last = cyc;
        n++;
        addr[0] = 16'h0010 + 16'(n);
        if (n == 3) req[0] = 1'b0;
      end else begin
        addr[0] = 16'h01FF;
      end
    end
    req[0] = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_ack_count: got %0d want 3", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_range();
    test_wprot();
    test_rst_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
